inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect,
// and the decode-side instruction queue head.
interface inst_fetch_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory requests, redirect/flush handling,
// and a small circular instruction queue with a zero-latency head.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  localparam int unsigned      PTR_W   = $clog2(QDEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(QDEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {RUN, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        drop_q, drop_d;

  logic [31:0]      qi_q [QDEPTH];
  logic [31:0]      qp_q [QDEPTH];
  logic [PTR_W-1:0] head_q, tail_q, last_ptr;
  logic [PTR_W:0]   count_q;

  logic        full, empty, redirect, stale, rsp_live;
  logic        req_valid_c, fire, push, pop;
  logic [31:0] redirect_tgt;

  assign redirect     = bus.redirect_valid;
  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
  // drop_q marks a response still owed for a request abandoned by reset
  assign stale        = bus.rsp_valid && drop_q;
  assign rsp_live     = bus.rsp_valid && !drop_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign last_ptr     = head_q - PTR_ONE;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      drop_q        <= ((state_q != RUN) && !rsp_live) || (drop_q && !bus.rsp_valid);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
    end
  end

  // Next state
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = stale ? 1'b0 : drop_q;
    unique case (state_q)
      RUN:     if (fire) state_d = WAIT;
      WAIT: begin
        if (rsp_live)      state_d = RUN;
        else if (redirect) state_d = DROP;
      end
      DROP:    if (rsp_live) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (redirect) begin
      pc_d = redirect_tgt;
    end else if (fire) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
    end
  end

  // Outputs / queue controls; redirect outranks fire, push and pop
  always_comb begin
    req_valid_c = !rst && (state_q == RUN) && !full && !redirect;
    fire        = req_valid_c && bus.req_ready;
    push        = !rst && (state_q == WAIT) && rsp_live && !redirect;
    pop         = !rst && !empty && bus.inst_ready && !redirect;
  end

  assign bus.req_valid  = req_valid_c;
  assign bus.req_addr   = pc_q;
  assign bus.inst_valid = !rst && !empty;
  // When empty, show the slot just popped so the outputs hold their last value
  assign bus.inst       = rst ? '0 : (empty ? qi_q[last_ptr] : qi_q[head_q]);
  assign bus.inst_pc    = rst ? '0 : (empty ? qp_q[last_ptr] : qp_q[head_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        qi_q[i] <= '0;
        qp_q[i] <= '0;
      end
    end else if (redirect) begin
      tail_q  <= head_q;
      count_q <= '0;
    end else begin
      if (push) begin
        qi_q[tail_q] <= bus.rsp_data;
        qp_q[tail_q] <= inflight_pc_q;
        tail_q       <= tail_q + PTR_ONE;
      end
      if (pop) head_q <= head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle-by-cycle stimulus with hand-computed expectations.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad   = 0;

  inst_fetch_if bus_if ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs at the falling edge, then settle before checks.
  task automatic drive(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic rdv, input logic [31:0] rdpc, input logic ir);
    @(negedge clk);
    rst                   = r;
    bus_if.req_ready      = rr;
    bus_if.rsp_valid      = rv;
    bus_if.rsp_data       = rd;
    bus_if.redirect_valid = rdv;
    bus_if.redirect_pc    = rdpc;
    bus_if.inst_ready     = ir;
    #1;
  endtask

  initial begin
    bus_if.req_ready      = 1'b0;
    bus_if.rsp_valid      = 1'b0;
    bus_if.rsp_data       = '0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.inst_ready     = 1'b0;

    // reset
    drive(1, 1, 0, 0, 0, 0, 1);
    check("rst_req_valid", 32'(bus_if.req_valid), 0);
    check("rst_inst_valid", 32'(bus_if.inst_valid), 0);
    check("rst_inst", bus_if.inst, 0);
    check("rst_inst_pc", bus_if.inst_pc, 0);

    // streaming with 1-cycle memory
    drive(0, 1, 0, 0, 0, 0, 1);                          // c0
    check("c0_req_valid", 32'(bus_if.req_valid), 1);
    check("c0_req_addr", bus_if.req_addr, 32'h0);
    drive(0, 1, 1, word_at(32'h0), 0, 0, 1);             // c1
    check("c1_req_valid", 32'(bus_if.req_valid), 0);
    check("c1_inst_valid", 32'(bus_if.inst_valid), 0);
    drive(0, 1, 0, 0, 0, 0, 1);                          // c2
    check("c2_inst_valid", 32'(bus_if.inst_valid), 1);
    check("c2_inst_pc", bus_if.inst_pc, 32'h0);
    check("c2_inst", bus_if.inst, word_at(32'h0));
    check("c2_req_addr", bus_if.req_addr, 32'h4);
    drive(0, 1, 1, word_at(32'h4), 0, 0, 1);             // c3
    check("c3_inst_valid", 32'(bus_if.inst_valid), 0);
    drive(0, 1, 0, 0, 0, 0, 1);                          // c4
    check("c4_inst_pc", bus_if.inst_pc, 32'h4);
    check("c4_inst", bus_if.inst, word_at(32'h4));
    check("c4_req_addr", bus_if.req_addr, 32'h8);
    drive(0, 1, 1, word_at(32'h8), 0, 0, 1);             // c5

    // backpressure from decode fills the queue
    drive(0, 1, 0, 0, 0, 0, 0);                          // c6
    check("c6_inst_pc", bus_if.inst_pc, 32'h8);
    check("c6_req_addr", bus_if.req_addr, 32'hC);
    drive(0, 1, 1, word_at(32'hC), 0, 0, 0);             // c7
    check("c7_req_valid", 32'(bus_if.req_valid), 0);
    for (int i = 0; i < 2; i++) begin                    // c8, c9
      drive(0, 1, 0, 0, 0, 0, 0);
      check("full_req_valid", 32'(bus_if.req_valid), 0);
      check("full_inst_pc", bus_if.inst_pc, 32'h8);
    end
    drive(0, 1, 0, 0, 0, 0, 1);                          // c10
    check("c10_inst_pc", bus_if.inst_pc, 32'h8);
    check("c10_req_valid", 32'(bus_if.req_valid), 0);
    drive(0, 1, 0, 0, 0, 0, 1);                          // c11
    check("c11_inst_pc", bus_if.inst_pc, 32'hC);
    check("c11_inst", bus_if.inst, word_at(32'hC));
    check("c11_req_addr", bus_if.req_addr, 32'h10);

    // redirect while a request is in flight
    drive(0, 1, 0, 0, 1, 32'h0000_0103, 1);              // c12
    check("c12_req_valid", 32'(bus_if.req_valid), 0);
    drive(0, 1, 1, word_at(32'h10), 0, 0, 1);            // c13
    check("c13_req_valid", 32'(bus_if.req_valid), 0);
    check("c13_inst_valid", 32'(bus_if.inst_valid), 0);

    // memory stall: address stable for 5 cycles
    for (int i = 0; i < 5; i++) begin                    // c14..c18
      drive(0, 0, 0, 0, 0, 0, 1);
      check("stall_req_valid", 32'(bus_if.req_valid), 1);
      check("stall_req_addr", bus_if.req_addr, 32'h100);
      check("stall_inst_valid", 32'(bus_if.inst_valid), 0);
    end
    drive(0, 1, 0, 0, 0, 0, 1);                          // c19
    check("c19_req_addr", bus_if.req_addr, 32'h100);

    // redirect coincides with the response
    drive(0, 1, 1, word_at(32'h100), 1, 32'h0000_0200, 1); // c20
    check("c20_req_valid", 32'(bus_if.req_valid), 0);
    drive(0, 1, 0, 0, 0, 0, 1);                          // c21
    check("c21_inst_valid", 32'(bus_if.inst_valid), 0);
    check("c21_req_valid", 32'(bus_if.req_valid), 1);
    check("c21_req_addr", bus_if.req_addr, 32'h200);
    drive(0, 1, 1, word_at(32'h200), 0, 0, 1);           // c22
    drive(0, 1, 0, 0, 0, 0, 1);                          // c23
    check("c23_inst_pc", bus_if.inst_pc, 32'h200);
    check("c23_inst", bus_if.inst, word_at(32'h200));
    check("c23_req_addr", bus_if.req_addr, 32'h204);

    // reset in WAIT; the stale response arrives later
    drive(1, 1, 0, 0, 0, 0, 1);                          // c24
    check("c24_req_valid", 32'(bus_if.req_valid), 0);
    check("c24_inst_valid", 32'(bus_if.inst_valid), 0);
    check("c24_inst", bus_if.inst, 0);
    drive(0, 1, 0, 0, 0, 0, 0);                          // c25
    check("c25_req_valid", 32'(bus_if.req_valid), 1);
    check("c25_req_addr", bus_if.req_addr, 32'h0);
    drive(0, 1, 0, 0, 0, 0, 0);                          // c26
    check("c26_req_valid", 32'(bus_if.req_valid), 0);
    drive(0, 1, 1, word_at(32'h204), 0, 0, 0);           // c27
    drive(0, 1, 1, word_at(32'h0), 0, 0, 0);             // c28
    check("c28_inst_valid", 32'(bus_if.inst_valid), 0);
    check("c28_req_valid", 32'(bus_if.req_valid), 0);
    drive(0, 1, 0, 0, 0, 0, 1);                          // c29
    check("c29_inst_valid", 32'(bus_if.inst_valid), 1);
    check("c29_inst_pc", bus_if.inst_pc, 32'h0);
    check("c29_inst", bus_if.inst, word_at(32'h0));
    drive(0, 1, 1, word_at(32'h4), 0, 0, 0);             // c30

    // redirect blocks pop; target low bits cleared; pc wraps past the top
    drive(0, 1, 0, 0, 1, 32'hFFFF_FFFF, 1);              // c31
    check("c31_inst_valid", 32'(bus_if.inst_valid), 1);
    check("c31_inst_pc", bus_if.inst_pc, 32'h4);
    check("c31_req_valid", 32'(bus_if.req_valid), 0);
    drive(0, 1, 0, 0, 0, 0, 1);                          // c32
    check("c32_inst_valid", 32'(bus_if.inst_valid), 0);
    check("c32_req_addr", bus_if.req_addr, 32'hFFFF_FFFC);
    drive(0, 1, 1, word_at(32'hFFFF_FFFC), 0, 0, 0);     // c33
    drive(0, 1, 0, 0, 0, 0, 0);                          // c34
    check("c34_inst_pc", bus_if.inst_pc, 32'hFFFF_FFFC);
    check("c34_inst", bus_if.inst, word_at(32'hFFFF_FFFC));
    check("c34_req_addr", bus_if.req_addr, 32'h0);
    check("c34_req_valid", 32'(bus_if.req_valid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
